// File: rtl/sd_debounce_pkg.sv
// Shared types and constants for the pad-input debounce filter.
package sd_debounce_pkg;

  localparam int unsigned GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } deb_state_t;

  // Resting state that corresponds to a given output level.
  function automatic deb_state_t stable_of(input logic level);
    return level ? STABLE_HI : STABLE_LO;
  endfunction

  // Level presented on sig_out while in a given state.
  function automatic logic level_of(input deb_state_t st);
    return (st == STABLE_HI) || (st == CHECK_LO);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
module bit_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the flop chain; the last flop is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Synchronise a pad level and only pass transitions that hold for
// STABLE_CYCLES consecutive samples; aborted candidates are counted.
module sig_debounce
  import sd_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          RESET_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                async_in,
  input  logic                en,
  input  logic                clr_glitch,
  output logic                sig_out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic          s;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_c;

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RESET_VAL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (async_in),
    .q  (s)
  );

  // State, counter and registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= stable_of(RESET_VAL);
      cnt_q   <= '0;
      sig_out <= RESET_VAL;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_out <= level_of(state_d);
      busy    <= (state_d == CHECK_HI) || (state_d == CHECK_LO);
    end
  end

  // Next-state: qualify a differing level, abort if it reverts early.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_c = 1'b0;
    if (!en) begin
      state_d = stable_of(sig_out);
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE_LO, STABLE_HI: begin
          if (s != sig_out) begin
            if (STABLE_CYCLES == 1) begin
              state_d = stable_of(~sig_out);
              cnt_d   = '0;
            end else begin
              state_d = sig_out ? CHECK_LO : CHECK_HI;
              cnt_d   = CW'(1);
            end
          end
        end
        CHECK_HI, CHECK_LO: begin
          if (s != sig_out) begin
            if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
              state_d = stable_of(~sig_out);
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = stable_of(sig_out);
            cnt_d   = '0;
            abort_c = 1'b1;
          end
        end
        default: begin
          state_d = stable_of(sig_out);
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear on the same edge as an abort wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   glitch_cnt <= '0;
    else if (clr_glitch)                       glitch_cnt <= '0;
    else if (abort_c && glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
  end

endmodule

// File: tb/tb_sig_debounce.sv
// Randomised and directed bench for sig_debounce against a run-length model.
module tb_sig_debounce;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;
  localparam bit          RVAL   = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       async_in;
  logic       en;
  logic       clr_glitch;
  logic       sig_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: history of pad samples plus a differing-run counter.
  bit hist[$];
  int run;
  bit m_out;
  int m_glitch;

  bit prev_out;
  int rises;
  int falls;

  sig_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_VAL    (RVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .en        (en),
    .clr_glitch(clr_glitch),
    .sig_out   (sig_out),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    run      = 0;
    m_out    = RVAL;
    m_glitch = 0;
    prev_out = RVAL;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit s;
    bit abort;
    s     = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : RVAL;
    abort = 1'b0;
    hist.push_back(async_in);
    if (!en) begin
      run = 0;
    end else if (s != m_out) begin
      run++;
      if (run == STABLE) begin
        m_out = ~m_out;
        run   = 0;
      end
    end else if (run > 0) begin
      run   = 0;
      abort = 1'b1;
    end
    if (clr_glitch)                 m_glitch = 0;
    else if (abort && m_glitch < 255) m_glitch++;
  endtask

  // One clock: advance model, sample DUT just after the edge, compare.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    chk("sig_out", int'(sig_out), int'(m_out));
    chk("busy", int'(busy), (run > 0) ? 1 : 0);
    chk("glitch_cnt", int'(glitch_cnt), m_glitch);
    if (sig_out && !prev_out) rises++;
    if (!sig_out && prev_out) falls++;
    prev_out = sig_out;
  endtask

  // Drive a level and report the edge count to the output change and busy cycles.
  task automatic qualify(input bit val, input int ncyc, output int edge_at, output int busy_n);
    edge_at  = 0;
    busy_n   = 0;
    async_in = val;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (busy) busy_n++;
      if (edge_at == 0 && sig_out == val) edge_at = i;
    end
  endtask

  task automatic glitch(input bit val, input int width, input int settle);
    async_in = val;
    repeat (width) step();
    async_in = ~val;
    repeat (settle) step();
  endtask

  initial begin
    int e, b, r0, f0;
    rst        = 1'b1;
    async_in   = 1'b1;
    en         = 1'b1;
    clr_glitch = 1'b0;
    rises      = 0;
    falls      = 0;
    model_reset();

    // 1: reset with pad high, release at 3.2 clock periods
    #5;
    chk("rst_sig_out", int'(sig_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_glitch", int'(glitch_cnt), 0);
    #59;
    rst = 1'b0;
    qualify(1'b1, 10, e, b);
    chk("t1_latency", e, 6);
    chk("t1_busy_cycles", b, 3);
    chk("t1_rises", rises, 1);

    // 2: clean 1->0 then 0->1
    f0 = falls;
    qualify(1'b0, 10, e, b);
    chk("t2_fall_latency", e, 6);
    chk("t2_fall_busy", b, 3);
    chk("t2_falls", falls - f0, 1);
    r0 = rises;
    qualify(1'b1, 10, e, b);
    chk("t2_rise_latency", e, 6);
    chk("t2_rise_busy", b, 3);
    chk("t2_rises", rises - r0, 1);
    qualify(1'b0, 10, e, b);

    // 3: three-cycle high glitch, then saturation
    r0 = rises;
    glitch(1'b1, 3, 6);
    chk("t3_sig_out", int'(sig_out), 0);
    chk("t3_no_rise", rises - r0, 0);
    chk("t3_glitch_one", int'(glitch_cnt), 1);
    for (int i = 0; i < 300; i++) glitch(1'b1, 3, 3);
    repeat (3) step();
    chk("t3_glitch_sat", int'(glitch_cnt), 255);

    // 4: clear coincident with an abort
    async_in = 1'b1;
    repeat (3) step();
    async_in = 1'b0;
    repeat (2) step();
    chk("t4_busy_before", int'(busy), 1);
    clr_glitch = 1'b1;
    step();
    clr_glitch = 1'b0;
    chk("t4_clear_wins", int'(glitch_cnt), 0);
    repeat (3) step();

    // 5: drop enable mid-qualification, then requalify
    async_in = 1'b1;
    repeat (4) step();
    chk("t5_busy_check", int'(busy), 1);
    en = 1'b0;
    step();
    chk("t5_busy_off", int'(busy), 0);
    chk("t5_sig_out", int'(sig_out), 0);
    chk("t5_glitch_hold", int'(glitch_cnt), 0);
    repeat (3) step();
    en = 1'b1;
    qualify(1'b1, 8, e, b);
    chk("t5_requal_edges", e, 4);
    chk("t5_requal_busy", b, 3);

    // 6: async reset mid CHECK_LO with a non-zero glitch count
    glitch(1'b0, 3, 6);
    chk("t6_glitch_pre", int'(glitch_cnt), 1);
    async_in = 1'b0;
    repeat (4) step();
    chk("t6_busy_pre", int'(busy), 1);
    #4;
    rst = 1'b1;
    #1;
    chk("t6_rst_sig_out", int'(sig_out), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_glitch", int'(glitch_cnt), 0);
    model_reset();
    repeat (2) step();
    #3;
    rst = 1'b0;
    qualify(1'b1, 10, e, b);
    chk("t6_post_latency", e, 6);

    // 7: randomised run lengths, enable and clear
    for (int i = 0; i < 400; i++) begin
      int len;
      async_in = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        en         = ($urandom_range(0, 19) != 0);
        clr_glitch = ($urandom_range(0, 49) == 0);
        step();
      end
    end
    en         = 1'b1;
    clr_glitch = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
